// File: rtl/capture_pkg.sv
// rtl/capture_pkg.sv - shared widths, FSM encoding and frame helpers for serial_capture
package capture_pkg;

  localparam int FRAME_W = 8;
  localparam int SLOT_W  = 3;

  typedef enum logic {
    HUNT    = 1'b0,
    CAPTURE = 1'b1
  } state_e;

  function automatic logic frame_xor(input logic [FRAME_W-1:0] f);
    return ^f;
  endfunction

endpackage

// File: rtl/frame_buffer.sv
// rtl/frame_buffer.sv - output holding register with valid/ready handshake and overflow pulse
// Optional parity output enabled by CAPTURE_PARITY_EN.
module frame_buffer
  import capture_pkg::*;
(
  input  logic               clock,
  input  logic               clear,
  input  logic               load_valid,
  input  logic [FRAME_W-1:0] load_data,
  input  logic               frame_ready,
  output logic [FRAME_W-1:0] frame_data,
  output logic               frame_valid,
  output logic               overflow
`ifdef CAPTURE_PARITY_EN
  ,
  output logic               frame_parity
`endif
);

  logic [FRAME_W-1:0] data_q, data_d;
  logic               valid_q, valid_d;
  logic               ovf_q, ovf_d;
`ifdef CAPTURE_PARITY_EN
  logic               parity_q, parity_d;
`endif

  // A new frame may replace the held one only if the held one is leaving this cycle.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ovf_d   = 1'b0;
`ifdef CAPTURE_PARITY_EN
    parity_d = parity_q;
`endif
    if (load_valid) begin
      if (!valid_q || frame_ready) begin
        data_d  = load_data;
        valid_d = 1'b1;
`ifdef CAPTURE_PARITY_EN
        parity_d = frame_xor(load_data);
`endif
      end else begin
        ovf_d = 1'b1;
      end
    end else if (valid_q && frame_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
`ifdef CAPTURE_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
`ifdef CAPTURE_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign frame_data  = data_q;
  assign frame_valid = valid_q;
  assign overflow    = ovf_q;
`ifdef CAPTURE_PARITY_EN
  assign frame_parity = parity_q;
`endif

endmodule

// File: rtl/serial_capture.sv
// rtl/serial_capture.sv - slot-aligned serial-to-parallel frame capture (HUNT/CAPTURE FSM)
// Optional parity output enabled by CAPTURE_PARITY_EN.
module serial_capture
  import capture_pkg::*;
#(
  parameter int RESYNC = 1
) (
  input  logic               clock,
  input  logic               clear,
  input  logic               bit_in,
  input  logic [SLOT_W-1:0]  slot,
  input  logic               bit_valid,
  output logic [FRAME_W-1:0] frame_data,
  output logic               frame_valid,
  input  logic               frame_ready,
  output logic               overflow,
  output logic               sync_err
`ifdef CAPTURE_PARITY_EN
  ,
  output logic               frame_parity
`endif
);

  localparam bit                RESYNC_EN = (RESYNC != 0);
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(FRAME_W - 1);

  state_e             state_q, state_d;
  logic [SLOT_W-1:0]  exp_q, exp_d;
  logic [FRAME_W-1:0] shreg_q, shreg_d;
  logic               serr_q, serr_d;

  logic               slot_hit;
  logic [FRAME_W-1:0] written;
  logic               frame_done;

  assign slot_hit = (slot == exp_q);

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q <= HUNT;
      exp_q   <= '0;
      shreg_q <= '0;
      serr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      exp_q   <= exp_d;
      shreg_q <= shreg_d;
      serr_q  <= serr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      HUNT:    if (bit_valid && slot == '0) state_d = CAPTURE;
      CAPTURE: if (bit_valid && !slot_hit && RESYNC_EN && slot != '0) state_d = HUNT;
      default: state_d = HUNT;
    endcase
  end

  // A slot-0 miss under RESYNC restarts the frame in place rather than waiting in HUNT.
  always_comb begin
    exp_d        = exp_q;
    shreg_d      = shreg_q;
    serr_d       = 1'b0;
    frame_done   = 1'b0;
    written      = shreg_q;
    written[slot] = bit_in;
    if (bit_valid) begin
      if (state_q == HUNT) begin
        if (slot == '0) begin
          shreg_d = {{(FRAME_W-1){1'b0}}, bit_in};
          exp_d   = SLOT_W'(1);
        end
      end else if (slot_hit || !RESYNC_EN) begin
        serr_d  = !slot_hit;
        shreg_d = written;
        exp_d   = slot + SLOT_W'(1);
        if (slot == LAST_SLOT) begin
          frame_done = 1'b1;
          shreg_d    = '0;
        end
      end else if (slot == '0) begin
        serr_d  = 1'b1;
        shreg_d = {{(FRAME_W-1){1'b0}}, bit_in};
        exp_d   = SLOT_W'(1);
      end else begin
        serr_d  = 1'b1;
        shreg_d = '0;
        exp_d   = '0;
      end
    end
  end

  assign sync_err = serr_q;

  frame_buffer u_frame_buffer (
    .clock       (clock),
    .clear       (clear),
    .load_valid  (frame_done),
    .load_data   (written),
    .frame_ready (frame_ready),
    .frame_data  (frame_data),
    .frame_valid (frame_valid),
    .overflow    (overflow)
`ifdef CAPTURE_PARITY_EN
    ,
    .frame_parity(frame_parity)
`endif
  );

endmodule

// File: tb/tb_serial_capture.sv
// tb/tb_serial_capture.sv - self-checking bench for serial_capture (RESYNC=1 and RESYNC=0 instances)
module tb_serial_capture;

  logic       clock = 1'b0;
  logic       clear = 1'b1;
  logic       bit_in = 1'b0;
  logic       bit_valid = 1'b0;
  logic       frame_ready = 1'b0;
  logic [2:0] slot = 3'd0;

  logic [7:0] fd1, fd0;
  logic       fv1, fv0, ov1, ov0, se1, se0;
`ifdef CAPTURE_PARITY_EN
  logic       fp1, fp0;
`endif

  always #5 clock = ~clock;

  serial_capture #(.RESYNC(1)) dut (
    .clock(clock), .clear(clear), .bit_in(bit_in), .slot(slot), .bit_valid(bit_valid),
    .frame_data(fd1), .frame_valid(fv1), .frame_ready(frame_ready),
    .overflow(ov1), .sync_err(se1)
`ifdef CAPTURE_PARITY_EN
    , .frame_parity(fp1)
`endif
  );

  serial_capture #(.RESYNC(0)) dut0 (
    .clock(clock), .clear(clear), .bit_in(bit_in), .slot(slot), .bit_valid(bit_valid),
    .frame_data(fd0), .frame_valid(fv0), .frame_ready(frame_ready),
    .overflow(ov0), .sync_err(se0)
`ifdef CAPTURE_PARITY_EN
    , .frame_parity(fp0)
`endif
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: index 1 = RESYNC=1, index 0 = RESYNC=0.
  bit         m_al[2];
  int         m_exp[2];
  logic [7:0] m_bits[2];
  logic [7:0] m_fd[2];
  bit         m_fv[2], m_ov[2], m_se[2];

  task automatic model_step(input int m);
    bit         done;
    logic [7:0] word;
    int         s;
    done = 0;
    word = 8'h00;
    s = int'(slot);
    if (clear) begin
      m_al[m] = 0; m_exp[m] = 0; m_bits[m] = 8'h00;
      m_fd[m] = 8'h00; m_fv[m] = 0; m_ov[m] = 0; m_se[m] = 0;
      return;
    end
    m_se[m] = 0;
    m_ov[m] = 0;
    if (bit_valid) begin
      if (!m_al[m]) begin
        if (s == 0) begin
          m_bits[m] = {7'b0, bit_in}; m_al[m] = 1; m_exp[m] = 1;
        end
      end else if (s == m_exp[m] || m == 0) begin
        m_se[m] = (s != m_exp[m]);
        m_bits[m][s] = bit_in;
        m_exp[m] = (s + 1) % 8;
        if (s == 7) begin
          done = 1; word = m_bits[m]; m_bits[m] = 8'h00;
        end
      end else begin
        m_se[m] = 1;
        if (s == 0) begin
          m_bits[m] = {7'b0, bit_in}; m_exp[m] = 1;
        end else begin
          m_al[m] = 0; m_bits[m] = 8'h00; m_exp[m] = 0;
        end
      end
    end
    if (done) begin
      if (m_fv[m] && !frame_ready) m_ov[m] = 1;
      else begin m_fd[m] = word; m_fv[m] = 1; end
    end else if (m_fv[m] && frame_ready) begin
      m_fv[m] = 0;
    end
  endtask

  task automatic compare_model();
    chk("r1_data", fd1, m_fd[1]);
    chk("r1_valid", fv1, m_fv[1]);
    chk("r1_ovf", ov1, m_ov[1]);
    chk("r1_serr", se1, m_se[1]);
    chk("r0_data", fd0, m_fd[0]);
    chk("r0_valid", fv0, m_fv[0]);
    chk("r0_ovf", ov0, m_ov[0]);
    chk("r0_serr", se0, m_se[0]);
`ifdef CAPTURE_PARITY_EN
    chk("r1_par", fp1, ^m_fd[1]);
    chk("r0_par", fp0, ^m_fd[0]);
`endif
  endtask

  task automatic tick(input logic c, input logic v, input logic [2:0] s, input logic b, input logic r);
    clear = c; bit_valid = v; slot = s; bit_in = b; frame_ready = r;
    @(posedge clock);
    model_step(0);
    model_step(1);
    #1;
    compare_model();
  endtask

  task automatic send_frame(input logic [7:0] f, input logic r);
    for (int k = 0; k < 8; k++) tick(1'b0, 1'b1, 3'(k), f[k], r);
  endtask

  typedef struct {
    logic       clr, v;
    logic [2:0] s;
    logic       b, r;
    logic [7:0] fd;
    logic       fv, ov, se;
  } vec_t;

  function automatic vec_t mk(input logic clr, input logic v, input logic [2:0] s, input logic b,
                              input logic r, input logic [7:0] fd, input logic fv, input logic ov,
                              input logic se);
    vec_t t;
    t.clr = clr; t.v = v; t.s = s; t.b = b; t.r = r; t.fd = fd; t.fv = fv; t.ov = ov; t.se = se;
    return t;
  endfunction

  vec_t tbl[$];

  initial begin
    logic [7:0] pat;
    int         rs;
    logic [2:0] s;
    logic       v;

    pat = 8'hF0;
    tbl.push_back(mk(1, 0, 0, 0, 0, 8'h00, 0, 0, 0));
    for (int k = 5; k < 8; k++) tbl.push_back(mk(0, 1, 3'(k), 1, 0, 8'h00, 0, 0, 0));
    for (int k = 0; k < 8; k++)
      tbl.push_back(mk(0, 1, 3'(k), pat[k], 0, (k == 7) ? pat : 8'h00, k == 7, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, pat, 0, 0, 0));

    foreach (tbl[i]) begin
      tick(tbl[i].clr, tbl[i].v, tbl[i].s, tbl[i].b, tbl[i].r);
      chk($sformatf("tbl%0d_data", i), fd1, tbl[i].fd);
      chk($sformatf("tbl%0d_valid", i), fv1, tbl[i].fv);
      chk($sformatf("tbl%0d_ovf", i), ov1, tbl[i].ov);
      chk($sformatf("tbl%0d_serr", i), se1, tbl[i].se);
    end

    // Back-to-back frames with the consumer always ready
    tick(1, 0, 0, 0, 1);
    send_frame(8'hF0, 1);
    chk("b2b_first_data", fd1, 8'hF0);
    chk("b2b_first_valid", fv1, 1);
    pat = 8'h0F;
    for (int k = 0; k < 8; k++) begin
      tick(0, 1, 3'(k), pat[k], 1);
      chk("b2b_no_err", {se1, ov1}, 2'b00);
    end
    chk("b2b_second_data", fd1, 8'h0F);
    chk("b2b_second_valid", fv1, 1);

    // Overflow while the consumer stalls
    tick(1, 0, 0, 0, 0);
    send_frame(8'hA5, 0);
    chk("ovf_first_valid", fv1, 1);
    chk("ovf_first_none", ov1, 0);
    send_frame(8'h3C, 0);
    chk("ovf_pulse", ov1, 1);
    chk("ovf_kept_data", fd1, 8'hA5);
    tick(0, 0, 0, 0, 0);
    chk("ovf_one_cycle", ov1, 0);
    chk("ovf_held_data", fd1, 8'hA5);
    tick(0, 0, 0, 0, 1);
    chk("ovf_drain_valid", fv1, 0);

    // Slot sequence break: 0,1,2 then 4
    tick(1, 0, 0, 0, 0);
    tick(0, 1, 3'd0, 1, 0);
    tick(0, 1, 3'd1, 1, 0);
    tick(0, 1, 3'd2, 1, 0);
    tick(0, 1, 3'd4, 1, 0);
    chk("serr_r1", se1, 1);
    chk("serr_r0", se0, 1);
    tick(0, 1, 3'd5, 1, 0);
    chk("serr_r1_pulse", se1, 0);
    chk("serr_r0_cont", se0, 0);
    tick(0, 1, 3'd6, 1, 0);
    tick(0, 1, 3'd7, 1, 0);
    chk("serr_r0_frame_valid", fv0, 1);
    chk("serr_r0_frame_data", fd0, 8'hF7);
    chk("serr_r1_hunt", fv1, 0);
    send_frame(8'h3C, 0);
    chk("serr_r1_realign_data", fd1, 8'h3C);
    chk("serr_r1_realign_valid", fv1, 1);
    chk("serr_r0_ovf", ov0, 1);

    // Clear mid-frame with a pending frame
    tick(1, 0, 0, 0, 0);
    send_frame(8'hC3, 0);
    for (int k = 0; k < 4; k++) tick(0, 1, 3'(k), 1, 0);
    tick(1, 1, 3'd4, 1, 0);
    chk("clr_valid", fv1, 0);
    chk("clr_data", fd1, 8'h00);
    chk("clr_pulses", {ov1, se1}, 2'b00);
    tick(0, 1, 3'd5, 1, 0);
    chk("clr_no_serr", se1, 0);
    send_frame(8'h5A, 0);
    chk("clr_realign_data", fd1, 8'h5A);
    chk("clr_realign_valid", fv1, 1);

`ifdef CAPTURE_PARITY_EN
    tick(1, 0, 0, 0, 1);
    send_frame(8'h07, 1);
    chk("par_07", fp1, 1);
    send_frame(8'hF0, 1);
    chk("par_F0", fp1, 0);
`endif

    // Randomized traffic against the model
    tick(1, 0, 0, 0, 0);
    rs = 0;
    for (int n = 0; n < 3000; n++) begin
      v = ($urandom_range(0, 3) != 0);
      s = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(0, 7)) : 3'(rs);
      if (v) rs = (int'(s) + 1) % 8;
      tick(($urandom_range(0, 299) == 0), v, s, 1'($urandom_range(0, 1)),
           ($urandom_range(0, 2) != 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
